iterative_mantissa_multiplier: RTL and testbench

//  Multi-cycle unsigned mantissa multiplier for the tiny FPU datapath. Takes one

---
 rtl/iterative_mantissa_multiplier.sv | 101 ++++++++++
 tb/tb_iterative_mantissa_multiplier.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iterative_mantissa_multiplier.sv
// Multi-cycle unsigned mantissa multiplier, DIGIT_BITS of b per cycle.
// Valid/ready in and out, optional early exit, pipeline flush.
module iterative_mantissa_multiplier #(
  parameter int PRECISION_BITS = 24,
  parameter int DIGIT_BITS     = 2,
  parameter bit EARLY_EXIT     = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [PRECISION_BITS-1:0]   mantissa_a_i,
  input  logic [PRECISION_BITS-1:0]   mantissa_b_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [2*PRECISION_BITS-1:0] product_o,
  output logic                        busy_o
);

  localparam int NUM_STEPS =
    (PRECISION_BITS + DIGIT_BITS - 1) / DIGIT_BITS;
  localparam int BW = NUM_STEPS * DIGIT_BITS;
  localparam int PW = 2 * PRECISION_BITS;
  localparam int CW =
    (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_STEPS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CW-1:0]         r_count;
  logic [PW-1:0]         r_a_sh;
  logic [PW-1:0]         r_acc;
  logic [BW-1:0]         r_b_sh;
  logic [DIGIT_BITS-1:0] w_digit;
  logic [PW-1:0]         w_pp;
  logic                  w_rest_zero;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_step;

  // b is kept right-shifted so the current digit is always at the bottom;
  // a is kept left-shifted so the partial product is already aligned.
  assign w_digit     = r_b_sh[DIGIT_BITS-1:0];
  assign w_pp        = r_a_sh * PW'(w_digit);
  assign w_rest_zero = (r_b_sh >> DIGIT_BITS) == '0;
  assign w_last      = (r_count == LAST) ||
                       (EARLY_EXIT && w_rest_zero);
  assign w_accept    = in_valid_i && (r_state == S_IDLE) && !flush_i;
  assign w_step      = (r_state == S_COMPUTE) && !flush_i;

  assign in_ready_o  = (r_state == S_IDLE);
  assign out_valid_o = (r_state == S_DONE);
  assign busy_o      = (r_state != S_IDLE);
  assign product_o   = out_valid_o ? r_acc : '0;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: flush overrides every transition
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (in_valid_i)  w_state_nxt = S_COMPUTE;
      S_COMPUTE: if (w_last)      w_state_nxt = S_DONE;
      S_DONE:    if (out_ready_i) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
    if (flush_i) w_state_nxt = S_IDLE;
  end

  // Operand latch, shift-and-accumulate datapath
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_a_sh  <= PW'(mantissa_a_i);
      r_b_sh  <= BW'(mantissa_b_i);
      r_acc   <= '0;
      r_count <= '0;
    end else if (w_step) begin
      r_acc   <= r_acc + w_pp;
      r_a_sh  <= r_a_sh << DIGIT_BITS;
      r_b_sh  <= r_b_sh >> DIGIT_BITS;
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_iterative_mantissa_multiplier.sv
// Bench for iterative_mantissa_multiplier: scoreboarded random/directed
// traffic on the default build, directed checks on two other builds.
module tb_iterative_mantissa_multiplier;

  typedef struct {
    logic [47:0] prod;
    int          cyc;
  } exp_t;

  logic clk;
  int   cyc;
  int   errors;
  int   checks;
  exp_t sb[$];

  // default build: P=24 D=2 EE=0
  logic        rst, flush, in_valid, out_ready;
  logic [23:0] a_i, b_i;
  logic        in_ready, out_valid, busy;
  logic [47:0] product;
  bit          rnd_rdy, force_lo;

  // early-exit build: P=24 D=2 EE=1
  logic        rst2, ee_valid, ee_ir, ee_ov, ee_busy;
  logic [23:0] ee_a, ee_b;
  logic [47:0] ee_p;

  // narrow build: P=11 D=4 EE=0
  logic        rst3, p_valid, p_ir, p_ov, p_busy;
  logic [10:0] p_a, p_b;
  logic [21:0] p_p;

  iterative_mantissa_multiplier #(
    .PRECISION_BITS(24), .DIGIT_BITS(2), .EARLY_EXIT(1'b0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .mantissa_a_i(a_i), .mantissa_b_i(b_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .product_o(product), .busy_o(busy)
  );

  iterative_mantissa_multiplier #(
    .PRECISION_BITS(24), .DIGIT_BITS(2), .EARLY_EXIT(1'b1)
  ) dut_ee (
    .clk_i(clk), .rst_i(rst2), .flush_i(1'b0),
    .in_valid_i(ee_valid), .in_ready_o(ee_ir),
    .mantissa_a_i(ee_a), .mantissa_b_i(ee_b),
    .out_valid_o(ee_ov), .out_ready_i(1'b1),
    .product_o(ee_p), .busy_o(ee_busy)
  );

  iterative_mantissa_multiplier #(
    .PRECISION_BITS(11), .DIGIT_BITS(4), .EARLY_EXIT(1'b0)
  ) dut_p11 (
    .clk_i(clk), .rst_i(rst3), .flush_i(1'b0),
    .in_valid_i(p_valid), .in_ready_o(p_ir),
    .mantissa_a_i(p_a), .mantissa_b_i(p_b),
    .out_valid_o(p_ov), .out_ready_i(1'b1),
    .product_o(p_p), .busy_o(p_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pick24();
    case ($urandom_range(0, 3))
      0:       return 24'h0;
      1:       return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  // downstream readiness for the default build
  always @(negedge clk) begin
    if (force_lo)     out_ready = 1'b0;
    else if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    else              out_ready = 1'b1;
  end

  // monitor: pops the scoreboard whenever a product is handed over
  bit          prev_v;
  bit          take_prev;
  logic [47:0] held;
  always @(negedge clk) begin
    #1;
    if (rst) begin
      prev_v    = 1'b0;
      take_prev = 1'b0;
    end else begin
      if (take_prev)
        chk(in_ready == 1'b1, "ready_after_take", 64'(in_ready), 64'd1);
      take_prev = 1'b0;
      chk(busy == !in_ready, "busy_vs_ready", 64'(busy), 64'(!in_ready));
      if (!out_valid) begin
        chk(product == '0, "product_zero_when_invalid",
            64'(product), 64'd0);
      end else begin
        if (!prev_v) begin
          if (sb.size() == 0)
            chk(1'b0, "unexpected_valid", 64'(product), 64'd0);
          else
            chk(cyc == sb[0].cyc, "latency",
                64'(cyc), 64'(sb[0].cyc));
          held = product;
        end else begin
          chk(product == held, "product_stable", 64'(product), 64'(held));
        end
        chk(!in_ready, "no_accept_in_done", 64'(in_ready), 64'd0);
        if (out_ready) begin
          if (sb.size() > 0) begin
            chk(product == sb[0].prod, "product",
                64'(product), 64'(sb[0].prod));
            void'(sb.pop_front());
          end
          take_prev = 1'b1;
        end
      end
      prev_v = out_valid && !out_ready;
    end
  end

  // issue one operand pair to the default build
  task automatic send(input logic [23:0] a, input logic [23:0] b);
    exp_t e;
    int   n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk(1'b0, "send_timeout", 64'(in_ready), 64'd1);
    end else begin
      in_valid = 1'b1;
      a_i      = a;
      b_i      = b;
      e.prod   = {24'h0, a} * {24'h0, b};
      e.cyc    = cyc + 13;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a_i      = 24'($urandom);
      b_i      = 24'($urandom);
    end
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(sb.size() == 0, "drain_timeout", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic run_ee(input logic [23:0] a, input logic [23:0] b);
    int          k, c0, n;
    logic [47:0] e;
    k = 0;
    for (int i = 0; i < 24; i++)
      if (b[i]) k = i / 2;
    e = {24'h0, a} * {24'h0, b};
    @(negedge clk);
    chk(ee_ir == 1'b1, "ee_ready", 64'(ee_ir), 64'd1);
    ee_valid = 1'b1;
    ee_a     = a;
    ee_b     = b;
    c0       = cyc;
    @(negedge clk);
    ee_valid = 1'b0;
    ee_a     = 24'($urandom);
    ee_b     = 24'($urandom);
    n = 0;
    while (!ee_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ee_ov) begin
      chk(1'b0, "ee_timeout", 64'(ee_ov), 64'd1);
    end else begin
      chk(cyc - c0 == k + 2, "ee_latency", 64'(cyc - c0), 64'(k + 2));
      chk(ee_p == e, "ee_product", 64'(ee_p), 64'(e));
    end
    @(negedge clk);
  endtask

  task automatic run_p11(input logic [10:0] a, input logic [10:0] b);
    int          c0, n;
    logic [21:0] e;
    e = {11'h0, a} * {11'h0, b};
    @(negedge clk);
    chk(p_ir == 1'b1, "p11_ready", 64'(p_ir), 64'd1);
    p_valid = 1'b1;
    p_a     = a;
    p_b     = b;
    c0      = cyc;
    @(negedge clk);
    p_valid = 1'b0;
    p_a     = 11'($urandom);
    p_b     = 11'($urandom);
    n = 0;
    while (!p_ov && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!p_ov) begin
      chk(1'b0, "p11_timeout", 64'(p_ov), 64'd1);
    end else begin
      chk(cyc - c0 == 4, "p11_latency", 64'(cyc - c0), 64'd4);
      chk(p_p == e, "p11_product", 64'(p_p), 64'(e));
    end
    @(negedge clk);
  endtask

  initial begin
    int n;
    bit seen;
    errors   = 0;
    checks   = 0;
    rst      = 1'b1;
    rst2     = 1'b1;
    rst3     = 1'b1;
    flush    = 1'b0;
    in_valid = 1'b0;
    a_i      = '0;
    b_i      = '0;
    rnd_rdy  = 1'b0;
    force_lo = 1'b0;
    ee_valid = 1'b0;
    ee_a     = '0;
    ee_b     = '0;
    p_valid  = 1'b0;
    p_a      = '0;
    p_b      = '0;
    repeat (3) @(negedge clk);
    chk(in_ready == 1'b1, "rst_in_ready", 64'(in_ready), 64'd1);
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(product == '0, "rst_product", 64'(product), 64'd0);
    rst  = 1'b0;
    rst2 = 1'b0;
    rst3 = 1'b0;

    // corner products with immediate acceptance
    send(24'hFFFFFF, 24'hFFFFFF);
    send(24'h800000, 24'h800000);
    send(24'h123456, 24'h000000);
    wait_empty();

    // downstream stalls in DONE
    force_lo = 1'b1;
    send(24'h3C5A96, 24'hA5F00F);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(out_valid == 1'b1, "stall_reach_done", 64'(out_valid), 64'd1);
    repeat (5) @(negedge clk);
    force_lo = 1'b0;
    wait_empty();

    // flush in the fifth COMPUTE cycle
    send(24'h123456, 24'hFFFFFF);
    repeat (4) @(negedge clk);
    chk(busy == 1'b1 && out_valid == 1'b0, "flush_in_compute",
        64'(busy), 64'd1);
    flush = 1'b1;
    void'(sb.pop_back());
    @(negedge clk);
    flush = 1'b0;
    chk(in_ready == 1'b1, "flush_to_idle", 64'(in_ready), 64'd1);
    chk(out_valid == 1'b0, "flush_no_valid", 64'(out_valid), 64'd0);
    send(24'hABCDEF, 24'h000002);
    wait_empty();

    // handshake coinciding with flush is dropped
    in_valid = 1'b1;
    flush    = 1'b1;
    a_i      = 24'h111111;
    b_i      = 24'h222222;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk(in_ready == 1'b1 && busy == 1'b0, "flush_drops_accept",
        64'(busy), 64'd0);
    send(24'h000001, 24'hFFFFFF);
    wait_empty();

    // random traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(pick24(), pick24());
    end
    wait_empty();
    rnd_rdy = 1'b0;

    // early-exit build
    run_ee(24'hABCDEF, 24'h000003);
    run_ee(24'h5A5A5A, 24'h000000);
    run_ee(24'hFFFFFF, 24'hC00000);
    for (int i = 0; i < 6; i++)
      run_ee(pick24(), 24'($urandom) >> $urandom_range(0, 23));

    // narrow build, then reset mid-COMPUTE
    run_p11(11'h7FF, 11'h7FF);
    run_p11(11'h400, 11'h003);
    @(negedge clk);
    p_valid = 1'b1;
    p_a     = 11'h7FF;
    p_b     = 11'h7FF;
    @(negedge clk);
    p_valid = 1'b0;
    rst3    = 1'b1;
    @(negedge clk);
    rst3    = 1'b0;
    chk(p_ir == 1'b1, "p11_rst_ready", 64'(p_ir), 64'd1);
    chk(p_ov == 1'b0, "p11_rst_valid", 64'(p_ov), 64'd0);
    chk(p_busy == 1'b0, "p11_rst_busy", 64'(p_busy), 64'd0);
    chk(p_p == '0, "p11_rst_product", 64'(p_p), 64'd0);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (p_ov) seen = 1'b1;
    end
    chk(!seen, "p11_no_valid_after_rst", 64'(seen), 64'd0);
    run_p11(11'($urandom), 11'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
